// File: rtl/led_pkg.sv
// Shared types and constants for the seven-segment value encoder.
// Holds the FSM state encoding, display limits and the double-dabble nibble helper.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } seg7_state_t;

  localparam int SEG7_DIGITS    = 4;
  localparam int SEG7_MAX_VALUE = 9999;
  localparam int BCD_NIBBLES    = 5;
  localparam int BCD_WIDTH      = 20;
  localparam int COUNT_WIDTH    = 5;

  // Double-dabble correction: a nibble of 5..9 would overflow past 9 when doubled.
  function automatic logic [3:0] dabble_adjust(input logic [3:0] nibble);
    if (nibble >= 4'd5) begin
      return nibble + 4'd3;
    end else begin
      return nibble;
    end
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble iteration: add-3 correction on all five
// BCD nibbles, then shift left by one taking the next binary MSB in.
module bcd_dabble_step
  import led_pkg::*;
(
  input  logic [BCD_WIDTH-1:0] scratch,
  input  logic                 msb,
  output logic [BCD_WIDTH-1:0] next_scratch
);

  logic [BCD_WIDTH-1:0] adjusted;

  // Correct every nibble, then shift the corrected register with the new bit.
  always_comb begin
    adjusted = '0;
    for (int i = 0; i < BCD_NIBBLES; i++) begin
      adjusted[i*4 +: 4] = dabble_adjust(scratch[i*4 +: 4]);
    end
    next_scratch = (adjusted << 1) | {{(BCD_WIDTH-1){1'b0}}, msb};
  end

endmodule

// File: rtl/seg7_value_encoder.sv
// Converts an unsigned binary value into four saturating BCD display digits
// using a sequential double-dabble engine, one bit per clock.
module seg7_value_encoder
  import led_pkg::*;
#(
  parameter int IN_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_value,
  input  logic                clear,
  output logic                seg7_valid,
  output logic [3:0]          bcd_data_0,
  output logic [3:0]          bcd_data_1,
  output logic [3:0]          bcd_data_2,
  output logic [3:0]          bcd_data_3,
  output logic                overflow
);

  seg7_state_t            state;
  seg7_state_t            state_next;
  logic                   accept;
  logic [IN_WIDTH-1:0]    value;
  logic [COUNT_WIDTH-1:0] count;
  logic [BCD_WIDTH-1:0]   scratch;
  logic [BCD_WIDTH-1:0]   step_scratch;

  bcd_dabble_step u_step (
    .scratch      (scratch),
    .msb          (value[IN_WIDTH-1]),
    .next_scratch (step_scratch)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; clear wins over any accept in the same cycle.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (in_valid) begin
            state_next = CONVERT;
            accept     = 1'b1;
          end else begin
            state_next = state;
          end
        end
        CONVERT: begin
          if (count == {COUNT_WIDTH{1'b0}}) begin
            state_next = DONE;
          end else begin
            state_next = CONVERT;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath and registered outputs; digits only change when a result lands or on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready   <= 1'b1;
      value      <= '0;
      count      <= '0;
      scratch    <= '0;
      seg7_valid <= 1'b0;
      overflow   <= 1'b0;
      bcd_data_0 <= 4'd0;
      bcd_data_1 <= 4'd0;
      bcd_data_2 <= 4'd0;
      bcd_data_3 <= 4'd0;
    end else begin
      in_ready <= (state_next != CONVERT);
      if (clear) begin
        count      <= '0;
        scratch    <= '0;
        seg7_valid <= 1'b0;
        overflow   <= 1'b0;
        bcd_data_0 <= 4'd0;
        bcd_data_1 <= 4'd0;
        bcd_data_2 <= 4'd0;
        bcd_data_3 <= 4'd0;
      end else if (accept) begin
        value      <= in_value;
        count      <= COUNT_WIDTH'(IN_WIDTH);
        scratch    <= '0;
        seg7_valid <= 1'b0;
      end else if (state == CONVERT) begin
        if (count != {COUNT_WIDTH{1'b0}}) begin
          scratch <= step_scratch;
          value   <= {value[IN_WIDTH-2:0], 1'b0};
          count   <= count - 5'd1;
        end else if (scratch[19:16] != 4'd0) begin
          // Ten-thousands present: the value cannot be shown in four digits.
          seg7_valid <= 1'b1;
          overflow   <= 1'b1;
          bcd_data_0 <= 4'd9;
          bcd_data_1 <= 4'd9;
          bcd_data_2 <= 4'd9;
          bcd_data_3 <= 4'd9;
        end else begin
          seg7_valid <= 1'b1;
          overflow   <= 1'b0;
          bcd_data_0 <= scratch[15:12];
          bcd_data_1 <= scratch[11:8];
          bcd_data_2 <= scratch[7:4];
          bcd_data_3 <= scratch[3:0];
        end
      end else begin
        seg7_valid <= seg7_valid;
      end
    end
  end

endmodule

// File: tb/tb_seg7_value_encoder.sv
// Self-checking bench for seg7_value_encoder: directed scenarios plus random
// values compared against an arithmetic decimal model.
module tb_seg7_value_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_value;
  logic        clear;
  logic        seg7_valid;
  logic [3:0]  bcd_data_0, bcd_data_1, bcd_data_2, bcd_data_3;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_digits;

  seg7_value_encoder #(.IN_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .clear      (clear),
    .seg7_valid (seg7_valid),
    .bcd_data_0 (bcd_data_0),
    .bcd_data_1 (bcd_data_1),
    .bcd_data_2 (bcd_data_2),
    .bcd_data_3 (bcd_data_3),
    .overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] digits();
    return {bcd_data_0, bcd_data_1, bcd_data_2, bcd_data_3};
  endfunction

  // Reference: decimal digits by division, saturated above 9999; bit 16 = overflow.
  function automatic logic [16:0] model(input int v);
    if (v > 9999) return {1'b1, 16'h9999};
    return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept v, optionally pulse a second request at convert cycle 5, check latency and result.
  task automatic run_convert(input int v, input string tag, input bit inject);
    logic [16:0] exp;
    exp = model(v);
    in_valid = 1'b1;
    in_value = 16'(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_ready_low"}, 32'(in_ready), 32'd0);
    chk({tag, "_valid_low"}, 32'(seg7_valid), 32'd0);
    for (int c = 1; c <= 16; c++) begin
      if (inject && c == 5) begin
        in_valid = 1'b1;
        in_value = 16'd5555;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    chk({tag, "_valid_before_done"}, 32'(seg7_valid), 32'd0);
    chk({tag, "_digits_held"}, 32'(digits()), 32'(prev_digits));
    @(posedge clk); #1;
    chk({tag, "_valid"}, 32'(seg7_valid), 32'd1);
    chk({tag, "_digits"}, 32'(digits()), 32'(exp[15:0]));
    chk({tag, "_overflow"}, 32'(overflow), 32'(exp[16]));
    chk({tag, "_ready_done"}, 32'(in_ready), 32'd1);
    prev_digits = exp[15:0];
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_value = 16'd0; clear = 1'b0;
    prev_digits = 16'd0;
    #2 rst = 1'b1;
    #1;
    chk("reset_ready", 32'(in_ready), 32'd1);
    chk("reset_valid", 32'(seg7_valid), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_digits", 32'(digits()), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_convert(1234, "v1234", 1'b0);
    run_convert(0, "v0", 1'b0);
    run_convert(9999, "v9999", 1'b0);
    run_convert(10000, "v10000", 1'b0);
    run_convert(65535, "v65535", 1'b0);
    run_convert(9998, "v9998", 1'b0);
    run_convert(4321, "v4321_inject", 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("inject_not_queued_ready", 32'(in_ready), 32'd1);
    chk("inject_not_queued_valid", 32'(seg7_valid), 32'd1);
    chk("inject_not_queued_digits", 32'(digits()), 32'h4321);

    // Clear at convert cycle 8 together with a fresh request.
    in_valid = 1'b1; in_value = 16'd800;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    clear = 1'b1; in_valid = 1'b1; in_value = 16'd777;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_ready", 32'(in_ready), 32'd1);
    chk("clear_valid", 32'(seg7_valid), 32'd0);
    chk("clear_overflow", 32'(overflow), 32'd0);
    chk("clear_digits", 32'(digits()), 32'd0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("clear_valid_stays_low", 32'(seg7_valid), 32'd0);
    end
    prev_digits = 16'd0;

    // Asynchronous reset in the middle of a conversion.
    run_convert(1234, "pre_rst", 1'b0);
    in_valid = 1'b1; in_value = 16'd5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    chk("async_rst_valid", 32'(seg7_valid), 32'd0);
    chk("async_rst_digits", 32'(digits()), 32'd0);
    #2 rst = 1'b0;
    prev_digits = 16'd0;
    run_convert(42, "v42_after_rst", 1'b0);

    for (int i = 0; i < 10; i++) begin
      int v;
      if (i % 2 == 0) v = int'($urandom_range(0, 9999));
      else v = int'($urandom_range(0, 65535));
      run_convert(v, "random", 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
